// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operand sequencer.
// The state encoding is shown on the board display, so its values are fixed.
package alu_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int SHIFT_W = 4;
    localparam int CNT_W   = 4;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_EXEC  = 2'd2,
        ST_SHOW  = 2'd3
    } seq_state_t;

    function automatic logic [2:0] pack_flags(input logic zero, input logic carry, input logic ovf);
        logic [2:0] f;
        f             = '0;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw board button.
// A held button produces exactly one single-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= async_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign pulse_out = r_sync2 & ~r_prev;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads ALU operands from the switch bus one button press at a time, waits for
// the ALU to settle, then captures the result and flags into holding registers.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_load,
    input  logic               clear,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [OP_W-1:0]    op_in,
    input  logic [SHIFT_W-1:0] shift_in,
    input  logic [DATA_W-1:0]  alu_y,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_s,
    output logic [SHIFT_W-1:0] alu_shift,
    output logic [DATA_W-1:0]  result,
    output logic [2:0]         flags,
    output logic [1:0]         state_o,
    output logic               busy,
    output logic               done
);

    logic w_press;

    seq_state_t         r_state;
    logic [DATA_W-1:0]  r_alu_a;
    logic [DATA_W-1:0]  r_alu_b;
    logic [OP_W-1:0]    r_alu_s;
    logic [SHIFT_W-1:0] r_alu_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_result;
    logic [2:0]         r_flags;
    logic               r_done;

    btn_sync_edge u_load_btn (
        .clk       (clk),
        .rst       (rst),
        .async_in  (btn_load),
        .pulse_out (w_press)
    );

    // clear outranks both a press and the EXEC capture; result/flags survive it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
            r_alu_shift <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_done      <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_s     <= '0;
            r_alu_shift <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SHOW: begin
                    if (w_press) begin
                        r_alu_a <= data_in;
                        r_state <= ST_GOT_A;
                    end
                end
                ST_GOT_A: begin
                    if (w_press) begin
                        r_alu_b     <= data_in;
                        r_alu_s     <= op_in;
                        r_alu_shift <= shift_in;
                        r_cnt       <= CNT_W'(WAIT_CYCLES);
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_result <= alu_y;
                        r_flags  <= pack_flags(alu_zero, alu_carry, alu_overflow);
                        r_done   <= 1'b1;
                        r_state  <= ST_SHOW;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign alu_shift = r_alu_shift;
    assign result    = r_result;
    assign flags     = r_flags;
    assign state_o   = r_state;
    assign busy      = (r_state == ST_EXEC);
    assign done      = r_done;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer, with a behavioural ALU feeding the
// DUT and expected results derived from the operands the bench itself loaded.
module tb_alu_op_sequencer;

    localparam int WAIT = 5;

    logic       clk;
    logic       rst;
    logic       btn_load;
    logic       clear;
    logic [7:0] data_in;
    logic [2:0] op_in;
    logic [3:0] shift_in;
    logic [7:0] alu_y;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_overflow;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_s;
    logic [3:0] alu_shift;
    logic [7:0] result;
    logic [2:0] flags;
    logic [1:0] state_o;
    logic       busy;
    logic       done;

    int n_total;
    int n_pass;

    logic [7:0] exp_a;
    logic [7:0] exp_result;
    logic [2:0] exp_flags;

    // Reference ALU: returns {overflow, carry, zero, y}
    function automatic logic [10:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic [3:0] sh);
        logic [8:0] w;
        logic [7:0] y;
        logic       c;
        logic       v;
        w = '0;
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; y = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; y = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (y[7] != a[7]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a << sh;
            3'd6: y = a >> sh;
            default: y = b;
        endcase
        return {v, c, (y == 8'h00), y};
    endfunction

    assign {alu_overflow, alu_carry, alu_zero, alu_y} = alu_fn(alu_a, alu_b, alu_s, alu_shift);

    alu_op_sequencer #(.WAIT_CYCLES(WAIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_load     (btn_load),
        .clear        (clear),
        .data_in      (data_in),
        .op_in        (op_in),
        .shift_in     (shift_in),
        .alu_y        (alu_y),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_s        (alu_s),
        .alu_shift    (alu_shift),
        .result       (result),
        .flags        (flags),
        .state_o      (state_o),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus_scramble();
        data_in  = 8'($urandom);
        op_in    = 3'($urandom);
        shift_in = 4'($urandom);
    endtask

    // Button goes high just after an edge; first sampled next edge, register loads two edges later.
    task automatic do_press_a(input logic [7:0] a);
        data_in  = a;
        btn_load = 1'b1;
        repeat (3) tick();
        btn_load = 1'b0;
        applyStimulus_scramble();
        exp_a = a;
        n_total++; if (alu_a !== a) $display("[TB] FAIL press_a_value: got %h want %h", alu_a, a); else n_pass++;
        n_total++; if (state_o !== 2'd1) $display("[TB] FAIL press_a_state: got %0d want 1", state_o); else n_pass++;
        n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL press_a_flags: done %b busy %b want 0 0", done, busy); else n_pass++;
        repeat (3) tick();
    endtask

    // mode: 0 normal, 1 press during EXEC, 2 reset two cycles into EXEC, 3 clear on capture cycle
    task automatic do_press_b(input logic [7:0] b, input logic [2:0] op, input logic [3:0] sh, input int mode);
        logic [10:0] m;
        logic        saw_done;
        data_in  = b;
        op_in    = op;
        shift_in = sh;
        btn_load = 1'b1;
        repeat (3) tick();
        btn_load = 1'b0;
        applyStimulus_scramble();
        m = alu_fn(exp_a, b, op, sh);
        n_total++; if (state_o !== 2'd2 || busy !== 1'b1) $display("[TB] FAIL exec_entry: state %0d busy %b want 2 1", state_o, busy); else n_pass++;
        n_total++; if ({alu_a, alu_b} !== {exp_a, b}) $display("[TB] FAIL exec_operands: got %h/%h want %h/%h", alu_a, alu_b, exp_a, b); else n_pass++;
        n_total++; if ({alu_s, alu_shift} !== {op, sh}) $display("[TB] FAIL exec_op_shift: got %0d/%0d want %0d/%0d", alu_s, alu_shift, op, sh); else n_pass++;
        for (int i = 1; i <= WAIT; i++) begin
            tick();
            if (mode == 1 && i == 1) btn_load = 1'b1;
            if (mode == 2 && i == 2) begin
                rst = 1'b1;
                #1;
                n_total++; if ({alu_a, alu_b, alu_s, alu_shift} !== 23'd0) $display("[TB] FAIL rst_exec_operands: got %h %h %h %h want 0", alu_a, alu_b, alu_s, alu_shift); else n_pass++;
                n_total++; if ({result, flags} !== 11'd0) $display("[TB] FAIL rst_exec_result: got %h %b want 0", result, flags); else n_pass++;
                n_total++; if ({state_o, busy, done} !== 4'd0) $display("[TB] FAIL rst_exec_state: got %0d %b %b want 0", state_o, busy, done); else n_pass++;
                saw_done = 1'b0;
                repeat (8) begin
                    tick();
                    if (done !== 1'b0) saw_done = 1'b1;
                end
                rst = 1'b0;
                repeat (WAIT + 2) begin
                    tick();
                    if (done !== 1'b0) saw_done = 1'b1;
                end
                n_total++; if (saw_done !== 1'b0) $display("[TB] FAIL rst_exec_no_done: got %b want 0", saw_done); else n_pass++;
                n_total++; if ({state_o, result} !== 10'd0) $display("[TB] FAIL rst_exec_after: state %0d result %h want 0 0", state_o, result); else n_pass++;
                exp_a = 8'h00; exp_result = 8'h00; exp_flags = 3'b000;
                return;
            end
            if (mode == 3 && i == WAIT) begin
                clear = 1'b0;
                n_total++; if ({state_o, done} !== 3'd0) $display("[TB] FAIL clr_cap_state: state %0d done %b want 0 0", state_o, done); else n_pass++;
                n_total++; if ({result, flags} !== {exp_result, exp_flags}) $display("[TB] FAIL clr_cap_held: got %h %b want %h %b", result, flags, exp_result, exp_flags); else n_pass++;
                n_total++; if ({alu_a, alu_b, alu_s, alu_shift} !== 23'd0) $display("[TB] FAIL clr_cap_zero: got %h %h %h %h want 0", alu_a, alu_b, alu_s, alu_shift); else n_pass++;
                saw_done = 1'b0;
                repeat (WAIT + 2) begin
                    tick();
                    if (done !== 1'b0 || state_o !== 2'd0) saw_done = 1'b1;
                end
                n_total++; if (saw_done !== 1'b0) $display("[TB] FAIL clr_cap_quiet: got %b want 0", saw_done); else n_pass++;
                exp_a = 8'h00;
                return;
            end
            if (i < WAIT) begin
                n_total++; if ({state_o, done} !== {2'd2, 1'b0}) $display("[TB] FAIL exec_wait_%0d: state %0d done %b want 2 0", i, state_o, done); else n_pass++;
                n_total++; if ({result, flags} !== {exp_result, exp_flags}) $display("[TB] FAIL exec_hold_%0d: got %h %b want %h %b", i, result, flags, exp_result, exp_flags); else n_pass++;
                if (mode == 3 && i == WAIT - 1) clear = 1'b1;
            end else begin
                n_total++; if ({state_o, done, busy} !== {2'd3, 1'b1, 1'b0}) $display("[TB] FAIL capture_state: state %0d done %b busy %b want 3 1 0", state_o, done, busy); else n_pass++;
                n_total++; if (result !== m[7:0]) $display("[TB] FAIL capture_result: got %h want %h", result, m[7:0]); else n_pass++;
                n_total++; if (flags !== m[10:8]) $display("[TB] FAIL capture_flags: got %b want %b", flags, m[10:8]); else n_pass++;
            end
        end
        exp_result = m[7:0];
        exp_flags  = m[10:8];
        tick();
        n_total++; if ({state_o, done} !== {2'd3, 1'b0}) $display("[TB] FAIL done_pulse: state %0d done %b want 3 0", state_o, done); else n_pass++;
        if (mode == 1) begin
            repeat (4) tick();
            n_total++; if (state_o !== 2'd3) $display("[TB] FAIL exec_press_ignored: got %0d want 3", state_o); else n_pass++;
            n_total++; if (alu_a !== exp_a) $display("[TB] FAIL exec_press_alu_a: got %h want %h", alu_a, exp_a); else n_pass++;
            btn_load = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        n_total++; if ({alu_a, alu_b, alu_s, alu_shift} !== 23'd0) $display("[TB] FAIL reset_operands: got %h %h %h %h want 0", alu_a, alu_b, alu_s, alu_shift); else n_pass++;
        n_total++; if ({result, flags} !== 11'd0) $display("[TB] FAIL reset_result: got %h %b want 0", result, flags); else n_pass++;
        n_total++; if ({state_o, busy, done} !== 4'd0) $display("[TB] FAIL reset_state: got %0d %b %b want 0", state_o, busy, done); else n_pass++;
        rst = 1'b0;
        repeat (3) tick();
        n_total++; if ({state_o, done} !== 3'd0) $display("[TB] FAIL reset_release: state %0d done %b want 0 0", state_o, done); else n_pass++;
    endtask

    task automatic test_basic_add();
        do_press_a(8'h3C);
        do_press_b(8'h05, 3'b000, 4'h2, 0);
        n_total++; if ({result, flags} !== {8'h41, 3'b000}) $display("[TB] FAIL basic_add: got %h %b want 41 000", result, flags); else n_pass++;
    endtask

    task automatic test_chain_from_show();
        do_press_a(8'h10);
        n_total++; if (result !== 8'h41) $display("[TB] FAIL chain_result_held: got %h want 41", result); else n_pass++;
        do_press_b(8'h20, 3'b001, 4'h0, 0);
    endtask

    task automatic test_flag_packing();
        do_press_a(8'hFF);
        do_press_b(8'h01, 3'b000, 4'h0, 0);
        n_total++; if ({result, flags} !== {8'h00, 3'b011}) $display("[TB] FAIL flag_packing: got %h %b want 00 011", result, flags); else n_pass++;
    endtask

    task automatic test_held_button();
        int         transitions;
        logic [1:0] prev;
        data_in     = 8'h55;
        btn_load    = 1'b1;
        prev        = state_o;
        transitions = 0;
        repeat (20) begin
            tick();
            if (state_o !== prev) transitions++;
            prev = state_o;
        end
        btn_load = 1'b0;
        exp_a    = 8'h55;
        applyStimulus_scramble();
        repeat (4) tick();
        n_total++; if (transitions !== 1) $display("[TB] FAIL held_transitions: got %0d want 1", transitions); else n_pass++;
        n_total++; if ({state_o, alu_a} !== {2'd1, 8'h55}) $display("[TB] FAIL held_load: state %0d alu_a %h want 1 55", state_o, alu_a); else n_pass++;
        do_press_b(8'h11, 3'd4, 4'd0, 1);
    endtask

    task automatic test_clear_priority();
        logic quiet;
        do_press_a(8'hA5);
        data_in  = 8'h77;
        op_in    = 3'd3;
        shift_in = 4'd1;
        btn_load = 1'b1;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        btn_load = 1'b0;
        n_total++; if ({state_o, done} !== 3'd0) $display("[TB] FAIL clear_prio_state: state %0d done %b want 0 0", state_o, done); else n_pass++;
        n_total++; if ({alu_a, alu_b, alu_s, alu_shift} !== 23'd0) $display("[TB] FAIL clear_prio_zero: got %h %h %h %h want 0", alu_a, alu_b, alu_s, alu_shift); else n_pass++;
        n_total++; if ({result, flags} !== {exp_result, exp_flags}) $display("[TB] FAIL clear_prio_held: got %h %b want %h %b", result, flags, exp_result, exp_flags); else n_pass++;
        quiet = 1'b1;
        repeat (WAIT + 3) begin
            tick();
            if (done !== 1'b0 || state_o !== 2'd0) quiet = 1'b0;
        end
        n_total++; if (quiet !== 1'b1) $display("[TB] FAIL clear_prio_quiet: got %b want 1", quiet); else n_pass++;
        exp_a = 8'h00;
    endtask

    task automatic test_clear_at_capture();
        do_press_a(8'h81);
        do_press_b(8'h7E, 3'd2, 4'd0, 3);
    endtask

    task automatic test_reset_mid_exec();
        do_press_a(8'h3C);
        do_press_b(8'h05, 3'd0, 4'd0, 2);
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 16; n++) begin
            do_press_a(8'($urandom));
            do_press_b(8'($urandom), 3'($urandom), 4'($urandom_range(0, 9)), 0);
        end
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        exp_a      = 8'h00;
        exp_result = 8'h00;
        exp_flags  = 3'b000;
        rst        = 1'b1;
        btn_load   = 1'b0;
        clear      = 1'b0;
        data_in    = 8'h00;
        op_in      = 3'd0;
        shift_in   = 4'd0;
        repeat (3) tick();
        test_reset();
        test_basic_add();
        test_chain_from_show();
        test_flag_packing();
        test_held_button();
        test_clear_priority();
        test_clear_at_capture();
        test_reset_mid_exec();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Operand/operation sequencer for the 8-bit ALU datapath. It takes operands one at a time from the shared 8-bit switch bus. Each press of a load button loads the next operand: A first, then B together with the op select and shift amount. It then waits a programmable settle time for the combinational ALU, captures the result and flags into holding registers, and signals completion. It sits between the board inputs and the ALU, and replaces direct operand-register loading in the top level.

## Interface
- WAIT_CYCLES, default 1: ALU settle cycles between operand commit and result capture; legal range 1..15.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_load  in  1  raw load button, asynchronous to clk; a rising edge advances the sequence
- clear  in  1  synchronous abort to IDLE
- data_in  in  8  operand bus (switches)
- op_in  in  3  ALU operation select
- shift_in  in  4  ALU shift amount
- alu_y  in  8  ALU result
- alu_zero, alu_carry, alu_overflow  in  1 each  ALU flags
- alu_a, alu_b  out  8 each  operands driven to the ALU
- alu_s  out  3  operation select driven to the ALU
- alu_shift  out  4  shift amount driven to the ALU
- result  out  8  captured ALU result
- flags  out  3  captured flags, packed as {overflow, carry, zero}
- state_o  out  2  current state encoding, for display
- busy  out  1  high while in EXEC
- done  out  1  one-cycle pulse when result and flags update

## Operation
Button conditioning:
- btn_load passes through a 2-flop synchronizer.
- A rising-edge detector follows the synchronizer and produces a single-cycle `press`.
- A button held high for any length of time yields exactly one press.

State machine, encoded IDLE=0, GOT_A=1, EXEC=2, SHOW=3:
- **IDLE**:
  - On press: alu_a <= data_in, then go to GOT_A.
- **GOT_A**:
  - On press: alu_b <= data_in, alu_s <= op_in, alu_shift <= shift_in.
  - Load the wait counter with WAIT_CYCLES, then go to EXEC.
- **EXEC**:
  - The counter decrements every cycle.
  - In the cycle the counter equals 1: result <= alu_y, flags <= {alu_overflow, alu_carry, alu_zero}, done <= 1, then go to SHOW.
  - Presses in EXEC are discarded, not queued.
- **SHOW**:
  - result and flags are held.
  - On press: alu_a <= data_in, then go to GOT_A. This starts a new operation.
  - result and flags keep their old value until the next capture.

clear:
- In any state, clear sends the FSM to IDLE next cycle.
- It zeroes alu_a, alu_b, alu_s, alu_shift and the wait counter.
- result and flags are retained.
- clear has priority over a simultaneous press and over a simultaneous EXEC capture. In both cases the capture does not occur and done stays 0.

Outputs:
- busy = (state == EXEC).
- done is registered and high only in the first cycle of SHOW.
- No arithmetic is performed in this block. All data paths are plain 8/3/4-bit register transfers, with no width extension.

## Timing
- Reset (async assert, released synchronously by the system) clears everything:
  - all outputs are 0 and state_o = IDLE;
  - synchronizer, edge-detect flops and wait counter are 0.
- Reset asserted mid-EXEC aborts immediately, with no capture.
- Press latency: btn_load first sampled high at edge k produces press during the cycle after edge k+1. The operand register updates at edge k+2.
- EXEC entry at edge E: result, flags and done update at edge E+WAIT_CYCLES, and state_o = SHOW from that same edge.
- The ALU operands are stable for the whole of EXEC, so the ALU sees constant inputs for at least WAIT_CYCLES cycles before capture.
- Minimum operation time from the A press edge to done is 2 presses plus WAIT_CYCLES cycles.

## Structure
- Package alu_seq_pkg holds:
  - the state enum (2-bit);
  - the flag bit indices FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVF=2;
  - the width localparams DATA_W=8, OP_W=3, SHIFT_W=4.
- Sub-module btn_sync_edge contains the 2-flop synchronizer and the rising-edge pulse, with ports clk, rst, async_in, pulse_out. It is reused for any other board buttons.
- The FSM, operand registers, wait counter and capture registers live in alu_op_sequencer.

## Test plan
- **Reset mid-operation:** load A=8'h3C, B=8'h05 with WAIT_CYCLES=4, then assert rst 2 cycles into EXEC -> all outputs 0, state_o=0, done never pulses.
- **Basic add:** press with data_in=8'h3C, then press with data_in=8'h05, op_in=3'b000, shift_in=4'h2; ALU model returns 8'h41, flags 0.
  - alu_a=8'h3C, alu_b=8'h05, alu_s=0, alu_shift=2.
  - result=8'h41 and flags=3'b000 exactly WAIT_CYCLES edges after EXEC entry.
  - done high for 1 cycle.
- **Flag packing:** ALU model returns alu_y=8'h00, zero=1, carry=1, overflow=0 -> result=8'h00, flags=3'b011.
- **Held button and presses in EXEC:** btn_load held high for 20 cycles -> exactly one transition. With WAIT_CYCLES=8, a press issued during EXEC -> ignored; state goes EXEC->SHOW, not onward to GOT_A.
- **Chaining from SHOW:** press with data_in=8'h10 -> alu_a=8'h10, state_o=GOT_A; result still 8'h41 until the next capture.
- **clear priority:** in GOT_A, assert clear in the same cycle as press -> state IDLE, alu_a=alu_b=0, result unchanged, no done.
